// File: rtl/pq_pkg.sv
// ============================================================================
// Module  : pq_pkg
// Brief   : Shared HWPQ types: kv_t pairs, queue cells, operation codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pq_pkg;

    localparam int PQ_CAPACITY = 7;
    localparam int PQ_KEY_W    = 8;
    localparam int PQ_VAL_W    = 8;
    localparam int PQ_CNT_W    = $clog2(PQ_CAPACITY + 1);

    typedef struct packed {
        logic [PQ_KEY_W-1:0] key;
        logic [PQ_VAL_W-1:0] val;
    } kv_t;

    localparam logic [PQ_KEY_W-1:0] KEYINF   = '1;
    localparam kv_t                 KV_EMPTY = {KEYINF, {PQ_VAL_W{1'b0}}};

    typedef struct packed {
        logic valid;
        kv_t  kv;
    } pq_cell_t;

    localparam pq_cell_t PQ_CELL_EMPTY = {1'b0, KV_EMPTY};

    // Operation already qualified against full/empty by the top level.
    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_INS  = 2'd1,
        OP_REM  = 2'd2,
        OP_REP  = 2'd3
    } pq_op_e;

    function automatic logic key_lt(input kv_t a, input kv_t b);
        return a.key < b.key;
    endfunction

endpackage : pq_pkg

`default_nettype wire

// File: rtl/pq_cell.sv
// ============================================================================
// Module  : pq_cell
// Brief   : Next-state logic of one queue slot (insert/remove/replace).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pq_cell
    import pq_pkg::*;
#(
    parameter bit HEAD = 1'b0
) (
    input  pq_cell_t i_cur,
    input  pq_cell_t i_lo,
    input  pq_cell_t i_up,
    input  kv_t      i_kvi,
    input  pq_op_e   i_op,
    input  logic     i_lo_ins,
    output logic     o_ins,
    output pq_cell_t o_next
);

    logic     w_ins;
    logic     w_up_ins;
    pq_cell_t w_new;

    // Strict compare keeps equal keys in arrival order.
    assign w_ins    = !i_cur.valid || key_lt(i_kvi, i_cur.kv);
    assign w_up_ins = !i_up.valid  || key_lt(i_kvi, i_up.kv);
    assign w_new    = {1'b1, i_kvi};
    assign o_ins    = w_ins;

    always_comb begin
        o_next = i_cur;
        unique case (i_op)
            OP_INS: begin
                if (i_lo_ins) begin
                    o_next = i_lo;
                end else if (w_ins) begin
                    o_next = w_new;
                end
            end
            OP_REM: o_next = i_up;
            // Head is being removed, so it never counts as an insert point holder.
            OP_REP: begin
                if (!w_up_ins) begin
                    o_next = i_up;
                end else if (HEAD || !w_ins) begin
                    o_next = w_new;
                end
            end
            default: o_next = i_cur;
        endcase
    end

endmodule : pq_cell

`default_nettype wire

// File: rtl/pq_shift_array.sv
// ============================================================================
// Module  : pq_shift_array
// Brief   : Shift-register priority queue, min key at head, 1 op/cycle.
//           Define PQ_DROP_MAX_EN to let inserts on a full queue evict the max.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pq_shift_array
    import pq_pkg::*;
#(
    parameter int CAP   = PQ_CAPACITY,
    parameter int CNT_W = $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  kv_t              kvi,
    input  logic             deq,
    output kv_t              kvo,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             drop
);

    pq_cell_t         r_cell [CAP];
    pq_cell_t         w_next [CAP];
    logic [CAP-1:0]   w_ins;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_ins_ok;
    pq_op_e           w_op;

    assign w_full  = (r_count == CNT_W'(CAP));
    assign w_empty = (r_count == '0);

`ifdef PQ_DROP_MAX_EN
    assign w_ins_ok = 1'b1;
`else
    assign w_ins_ok = !w_full;
`endif

    always_comb begin
        w_op = OP_HOLD;
        if (enq && deq && !w_empty) begin
            w_op = OP_REP;
        end else if (enq && w_ins_ok) begin
            w_op = OP_INS;
        end else if (deq && !w_empty) begin
            w_op = OP_REM;
        end
    end

    for (genvar i = 0; i < CAP; i++) begin : g_cell
        pq_cell_t w_lo;
        pq_cell_t w_up;
        logic     w_lo_ins;

        if (i == 0) begin : g_lo_head
            assign w_lo     = PQ_CELL_EMPTY;
            assign w_lo_ins = 1'b0;
        end else begin : g_lo_body
            assign w_lo     = r_cell[i-1];
            assign w_lo_ins = w_ins[i-1];
        end

        if (i == CAP - 1) begin : g_up_top
            assign w_up = PQ_CELL_EMPTY;
        end else begin : g_up_body
            assign w_up = r_cell[i+1];
        end

        pq_cell #(
            .HEAD (i == 0)
        ) u_cell (
            .i_cur    (r_cell[i]),
            .i_lo     (w_lo),
            .i_up     (w_up),
            .i_kvi    (kvi),
            .i_op     (w_op),
            .i_lo_ins (w_lo_ins),
            .o_ins    (w_ins[i]),
            .o_next   (w_next[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CAP; i++) begin
                r_cell[i] <= PQ_CELL_EMPTY;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < CAP; i++) begin
                r_cell[i] <= w_next[i];
            end
            if (w_op == OP_INS && !w_full) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_op == OP_REM) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

`ifdef PQ_DROP_MAX_EN
    logic r_drop;

    // Full insert without deq always discards exactly one pair (old max or kvi).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= enq && !deq && w_full;
        end
    end

    assign drop = r_drop;
`else
    assign drop = 1'b0;
`endif

    assign kvo   = r_cell[0].valid ? r_cell[0].kv : KV_EMPTY;
    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;

endmodule : pq_shift_array

`default_nettype wire

// File: tb/tb_pq_shift_array.sv
// ============================================================================
// Module  : tb_pq_shift_array
// Brief   : Directed vector bench for pq_shift_array (follows PQ_DROP_MAX_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pq_shift_array;
    import pq_pkg::*;

    localparam int CAP   = PQ_CAPACITY;
    localparam int CNT_W = $clog2(CAP + 1);

    typedef struct {
        logic        enq;
        logic        deq;
        logic [15:0] kvi;
        logic [15:0] exp_kvo;
        int          exp_cnt;
        logic [2:0]  exp_flg;   // {empty, full, drop}
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             enq;
    logic             deq;
    kv_t              kvi;
    kv_t              kvo;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             drop;

    int n_checks;
    int n_errors;
    vec_t vecs [$];
    logic [7:0] ord [CAP];

    pq_shift_array #(
        .CAP   (CAP),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enq   (enq),
        .kvi   (kvi),
        .deq   (deq),
        .kvo   (kvo),
        .empty (empty),
        .full  (full),
        .count (count),
        .drop  (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic d, input logic [7:0] k,
                                input logic [15:0] x, input int c, input logic [2:0] f);
        vec_t v;
        v.enq = e; v.deq = d; v.kvi = {k, k};
        v.exp_kvo = x; v.exp_cnt = c; v.exp_flg = f;
        return v;
    endfunction

    function automatic logic [15:0] kk(input logic [7:0] k);
        return {k, k};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] x, input int c,
                              input logic [2:0] f);
        check({tag, " kvo"},   32'(kvo), 32'(x));
        check({tag, " count"}, 32'(count), 32'(c));
        check({tag, " flags"}, 32'({empty, full, drop}), 32'(f));
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        enq = v.enq; deq = v.deq; kvi = v.kvi;
        @(posedge clk);
        #1;
        check_outs(tag, v.exp_kvo, v.exp_cnt, v.exp_flg);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; enq = 1'b0; deq = 1'b0; kvi = KV_EMPTY;

        // Sorted insert with duplicate keys, drain, empty-deq, empty replace.
        vecs.push_back(mk(1, 0, 8'd5,  kk(8'd5), 1, 3'b000));
        vecs.push_back(mk(1, 0, 8'd2,  kk(8'd2), 2, 3'b000));
        vecs.push_back(mk(1, 0, 8'd9,  kk(8'd2), 3, 3'b000));
        vecs.push_back(mk(1, 0, 8'd2,  kk(8'd2), 4, 3'b000));
        vecs[1].kvi = 16'h02AA; vecs[1].exp_kvo = 16'h02AA;
        vecs[2].exp_kvo = 16'h02AA;
        vecs[3].kvi = 16'h02BB; vecs[3].exp_kvo = 16'h02AA;
        vecs.push_back(mk(0, 1, 8'd0,  16'h02BB, 3, 3'b000));
        vecs.push_back(mk(0, 1, 8'd0,  kk(8'd5), 2, 3'b000));
        vecs.push_back(mk(0, 1, 8'd0,  kk(8'd9), 1, 3'b000));
        vecs.push_back(mk(0, 1, 8'd0,  KV_EMPTY, 0, 3'b100));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 8'd0, KV_EMPTY, 0, 3'b100));
        vecs.push_back(mk(1, 1, 8'hFF, 16'hFF12, 1, 3'b000));
        vecs[vecs.size()-1].kvi = 16'hFF12;
        vecs.push_back(mk(0, 1, 8'd0,  KV_EMPTY, 0, 3'b100));
        // Fill with 10..70, head stays 10.
        for (int i = 1; i <= CAP; i++)
            vecs.push_back(mk(1, 0, 8'(10 * i), kk(8'd10), i, (i == CAP) ? 3'b010 : 3'b000));
`ifdef PQ_DROP_MAX_EN
        vecs.push_back(mk(1, 0, 8'd3,  kk(8'd3),  CAP, 3'b011));
        vecs.push_back(mk(0, 0, 8'd0,  kk(8'd3),  CAP, 3'b010));
        vecs.push_back(mk(1, 1, 8'd35, kk(8'd10), CAP, 3'b010));
        ord[0] = 8'd20; ord[1] = 8'd30; ord[2] = 8'd35; ord[3] = 8'd40;
        ord[4] = 8'd50; ord[5] = 8'd60; ord[6] = 8'hFF;
`else
        vecs.push_back(mk(1, 0, 8'd3,  kk(8'd10), CAP, 3'b010));
        vecs.push_back(mk(0, 0, 8'd0,  kk(8'd10), CAP, 3'b010));
        vecs.push_back(mk(1, 1, 8'd35, kk(8'd20), CAP, 3'b010));
        ord[0] = 8'd30; ord[1] = 8'd35; ord[2] = 8'd40; ord[3] = 8'd50;
        ord[4] = 8'd60; ord[5] = 8'd70; ord[6] = 8'hFF;
`endif

        repeat (2) @(negedge clk);
        check_outs("reset_held", KV_EMPTY, 0, 3'b100);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs("reset", KV_EMPTY, 0, 3'b100);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Drain after replace: order must be ascending with 35 slotted in.
        for (int i = 0; i < CAP; i++) begin
            apply(mk(0, 1, 8'd0, (i < CAP - 1) ? kk(ord[i]) : KV_EMPTY, CAP - 1 - i,
                     (i == CAP - 1) ? 3'b100 : 3'b000), $sformatf("drain%0d", i));
        end

        // Back-to-back inserts, then asynchronous reset mid-cycle.
        for (int i = 1; i <= 4; i++) begin
            apply(mk(1, 0, 8'(i), kk(8'd1), i, 3'b000), $sformatf("pre_rst%0d", i));
        end
        @(negedge clk);
        enq = 1'b1; kvi = kk(8'd5);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", KV_EMPTY, 0, 3'b100);
        @(negedge clk);
        rst_n = 1'b1; enq = 1'b0;
        @(posedge clk);
        #1;
        check_outs("rst_release", KV_EMPTY, 0, 3'b100);
        apply(mk(1, 0, 8'd7, kk(8'd7), 1, 3'b000), "post_rst_enq");

        @(negedge clk);
        enq = 1'b0; deq = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pq_shift_array

`default_nettype wire
